// File: rtl/tone_sequencer.sv
// Step sequencer that plays a pattern of notes as generator register writes.
// Host writes share the same port and always win it.
module tone_sequencer #(
    parameter int unsigned STEPS   = 8,
    parameter int unsigned TEMPO_W = 16,
    localparam int unsigned SW     = $clog2(STEPS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [TEMPO_W-1:0] tempo,
    input  logic [SW-1:0]      last_step,
    input  logic               pat_we,
    input  logic [SW-1:0]      pat_addr,
    input  logic [11:0]        pat_data,
    input  logic               host_strobe,
    input  logic [2:0]         host_address,
    input  logic [4:0]         host_data,
    output logic               write_strobe,
    output logic [2:0]         address,
    output logic [4:0]         data,
    output logic [SW-1:0]      step_o,
    output logic               busy
);

    typedef enum logic [2:0] {StIdle, StWrPer, StWrVol, StWrEn, StWait, StStop} state_e;

    state_e               state_q, state_d;
    logic [SW-1:0]        step_q, step_d;
    logic [TEMPO_W-1:0]   cnt_q, cnt_d;
    logic [11:0]          cur_entry_q, cur_entry_d;
    logic [11:0]          pat_mem [STEPS];
    logic                 seq_issue;
    logic [2:0]           seq_addr;
    logic [4:0]           seq_data;
    logic [TEMPO_W-1:0]   tempo_last;

    // A tempo of 0 behaves as 1.
    assign tempo_last = (tempo == '0) ? '0 : tempo - 1'b1;

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        cnt_d       = cnt_q;
        cur_entry_d = cur_entry_q;
        seq_issue   = 1'b0;
        seq_addr    = 3'b000;
        seq_data    = 5'b00000;
        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d     = StWrPer;
                    step_d      = '0;
                    cur_entry_d = pat_mem[0];
                end
            end
            StWrPer: begin
                if (!run) begin
                    state_d = StStop;
                end else begin
                    seq_addr  = 3'b000;
                    seq_data  = cur_entry_q[11:7];
                    seq_issue = !host_strobe;
                    if (seq_issue) state_d = StWrVol;
                end
            end
            StWrVol: begin
                if (!run) begin
                    state_d = StStop;
                end else begin
                    seq_addr  = 3'b010;
                    seq_data  = {1'b0, cur_entry_q[6:3]};
                    seq_issue = !host_strobe;
                    if (seq_issue) state_d = StWrEn;
                end
            end
            StWrEn: begin
                if (!run) begin
                    state_d = StStop;
                end else begin
                    seq_addr  = 3'b101;
                    seq_data  = {2'b00, cur_entry_q[2:0]};
                    seq_issue = !host_strobe;
                    if (seq_issue) begin
                        state_d = StWait;
                        cnt_d   = '0;
                    end
                end
            end
            StWait: begin
                // The gap counter runs regardless of host traffic.
                if (!run) begin
                    state_d = StStop;
                end else if (cnt_q == tempo_last) begin
                    step_d      = (step_q >= last_step) ? '0 : step_q + 1'b1;
                    state_d     = StWrPer;
                    cur_entry_d = pat_mem[step_d];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                seq_addr  = 3'b101;
                seq_data  = 5'b00000;
                seq_issue = !host_strobe;
                if (seq_issue) begin
                    state_d = StIdle;
                    step_d  = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            step_q      <= '0;
            cnt_q       <= '0;
            cur_entry_q <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            cnt_q       <= cnt_d;
            cur_entry_q <= cur_entry_d;
        end
    end

    // Entry reads above see the pre-write contents on a same-edge write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STEPS; i++) pat_mem[i] <= '0;
        end else if (pat_we) begin
            pat_mem[pat_addr] <= pat_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_strobe <= 1'b0;
            address      <= 3'b000;
            data         <= 5'b00000;
        end else if (host_strobe) begin
            write_strobe <= 1'b1;
            address      <= host_address;
            data         <= host_data;
        end else if (seq_issue) begin
            write_strobe <= 1'b1;
            address      <= seq_addr;
            data         <= seq_data;
        end else begin
            write_strobe <= 1'b0;
        end
    end

    assign step_o = step_q;
    assign busy   = (state_q != StIdle);

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: directed scenarios plus random traffic, all checked
// every cycle against a phase-counting model of the pattern player.
module tb_tone_sequencer;

    logic        clk;
    logic        rst;
    logic        run;
    logic [15:0] tempo;
    logic [2:0]  last_step;
    logic        pat_we;
    logic [2:0]  pat_addr;
    logic [11:0] pat_data;
    logic        host_strobe;
    logic [2:0]  host_address;
    logic [4:0]  host_data;
    logic        write_strobe;
    logic [2:0]  address;
    logic [4:0]  data;
    logic [2:0]  step_o;
    logic        busy;

    int checks = 0;
    int errors = 0;

    tone_sequencer #(.STEPS(8), .TEMPO_W(16)) dut (
        .clk(clk), .rst(rst), .run(run), .tempo(tempo), .last_step(last_step),
        .pat_we(pat_we), .pat_addr(pat_addr), .pat_data(pat_data),
        .host_strobe(host_strobe), .host_address(host_address), .host_data(host_data),
        .write_strobe(write_strobe), .address(address), .data(data),
        .step_o(step_o), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 playing, 2 muting. ph counts cycles within a step;
    // ph 0..2 are the three note writes, ph >= 3 is the gap.
    int          m_mode, m_ph, m_step, m_w;
    logic [11:0] m_entry;
    logic [11:0] m_mem [8];
    logic        m_ws;
    logic [2:0]  m_a;
    logic [4:0]  m_d;
    logic        m_iss;
    logic [2:0]  m_sa;
    logic [4:0]  m_sd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_ph = 0; m_step = 0; m_entry = '0;
            m_ws = 1'b0; m_a = '0; m_d = '0;
            for (int i = 0; i < 8; i++) m_mem[i] = '0;
        end else begin
            m_iss = 1'b0; m_sa = '0; m_sd = '0;
            m_w = (tempo == 16'd0) ? 1 : int'(tempo);
            case (m_mode)
                0: if (run) begin
                    m_mode = 1; m_ph = 0; m_step = 0; m_entry = m_mem[0];
                end
                1: if (!run) begin
                    m_mode = 2;
                end else if (m_ph < 3) begin
                    if (!host_strobe) begin
                        m_iss = 1'b1;
                        if (m_ph == 0) begin m_sa = 3'd0; m_sd = m_entry[11:7]; end
                        else if (m_ph == 1) begin m_sa = 3'd2; m_sd = {1'b0, m_entry[6:3]}; end
                        else begin m_sa = 3'd5; m_sd = {2'b00, m_entry[2:0]}; end
                        m_ph++;
                    end
                end else if (m_ph - 3 == m_w - 1) begin
                    m_step  = (m_step >= int'(last_step)) ? 0 : m_step + 1;
                    m_ph    = 0;
                    m_entry = m_mem[m_step];
                end else begin
                    m_ph++;
                end
                default: if (!host_strobe) begin
                    m_iss = 1'b1; m_sa = 3'd5; m_sd = 5'd0; m_mode = 0; m_step = 0;
                end
            endcase
            if (host_strobe) begin
                m_ws = 1'b1; m_a = host_address; m_d = host_data;
            end else if (m_iss) begin
                m_ws = 1'b1; m_a = m_sa; m_d = m_sd;
            end else begin
                m_ws = 1'b0;
            end
            if (pat_we) m_mem[pat_addr] = pat_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("port", 32'({write_strobe, address, data}), 32'({m_ws, m_a, m_d}));
        chk("step_o", 32'(step_o), 32'(m_step));
        chk("busy", 32'(busy), 32'(m_mode != 0));
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            check_all();
        end
    endtask

    task automatic stop_run();
        run = 1'b0; host_strobe = 1'b0; pat_we = 1'b0;
        cyc(4);
        chk("stopped_idle", 32'(busy), 32'd0);
    endtask

    logic [11:0] e [3];
    logic [11:0] newv;
    int          wcount;

    initial begin
        rst = 1'b0; run = 1'b0; tempo = 16'd2; last_step = 3'd0;
        pat_we = 1'b0; pat_addr = 3'd0; pat_data = 12'd0;
        host_strobe = 1'b0; host_address = 3'd0; host_data = 5'd0;
        #1 rst = 1'b1;
        #2;
        chk("rst_ws", 32'(write_strobe), 32'd0);
        chk("rst_port", 32'({address, data}), 32'd0);
        chk("rst_step", 32'(step_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single-entry loop, tempo 2: 5-cycle period.
        pat_we = 1'b1; pat_addr = 3'd0; pat_data = {5'd3, 4'd9, 3'b111};
        cyc(1);
        pat_we = 1'b0; last_step = 3'd0; tempo = 16'd2; run = 1'b1;
        cyc(1);
        chk("t1_busy", 32'(busy), 32'd1);
        cyc(1); chk("t1_per", 32'({write_strobe, address, data}), 32'({1'b1, 3'd0, 5'd3}));
        cyc(1); chk("t1_vol", 32'({write_strobe, address, data}), 32'({1'b1, 3'd2, 5'd9}));
        cyc(1); chk("t1_en", 32'({write_strobe, address, data}), 32'({1'b1, 3'd5, 5'd7}));
        cyc(2);
        cyc(1); chk("t1_per2", 32'({write_strobe, address, data}), 32'({1'b1, 3'd0, 5'd3}));
        cyc(8);
        stop_run();

        // Three distinct entries, wrap after step 2.
        for (int i = 0; i < 3; i++) begin
            e[i] = {5'(i + 1), 4'($urandom), 3'($urandom)};
            pat_we = 1'b1; pat_addr = 3'(i); pat_data = e[i];
            cyc(1);
        end
        pat_we = 1'b0; last_step = 3'd2; tempo = 16'd1; run = 1'b1;
        cyc(1); chk("t2_step0", 32'(step_o), 32'd0);
        cyc(4); chk("t2_step1", 32'(step_o), 32'd1);
        cyc(4); chk("t2_step2", 32'(step_o), 32'd2);
        cyc(4); chk("t2_wrap", 32'(step_o), 32'd0);
        cyc(6);
        stop_run();

        // Host holds the port for two cycles while the volume write is pending.
        tempo = 16'd2; run = 1'b1;
        cyc(2);
        host_strobe = 1'b1; host_address = 3'd7; host_data = 5'h15;
        cyc(1); chk("t3_host1", 32'({write_strobe, address, data}), 32'({1'b1, 3'd7, 5'h15}));
        host_address = 3'd6; host_data = 5'h0a;
        cyc(1); chk("t3_host2", 32'({write_strobe, address, data}), 32'({1'b1, 3'd6, 5'h0a}));
        host_strobe = 1'b0;
        cyc(1); chk("t3_vol", 32'({write_strobe, address, data}), 32'({1'b1, 3'd2, 1'b0, e[0][6:3]}));
        cyc(1); chk("t3_en", 32'({write_strobe, address, data}), 32'({1'b1, 3'd5, 2'b00, e[0][2:0]}));
        cyc(1);

        // Drop run in the gap: exactly one mute write.
        run = 1'b0; wcount = 0;
        repeat (6) begin
            cyc(1);
            if (write_strobe) begin
                wcount++;
                chk("t4_mute", 32'({address, data}), 32'({3'd5, 5'd0}));
            end
        end
        chk("t4_writes", 32'(wcount), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_step", 32'(step_o), 32'd0);

        // tempo 0 and a pattern write on the edge that enters the first step.
        newv = {~e[0][11:7], e[0][6:0]};
        pat_we = 1'b1; pat_addr = 3'd0; pat_data = newv;
        tempo = 16'd0; last_step = 3'd0; run = 1'b1;
        cyc(1);
        pat_we = 1'b0;
        cyc(1); chk("t5_old", 32'({write_strobe, address, data}), 32'({1'b1, 3'd0, e[0][11:7]}));
        cyc(3);
        cyc(1); chk("t5_new", 32'({write_strobe, address, data}), 32'({1'b1, 3'd0, newv[11:7]}));
        cyc(8);
        stop_run();

        // Random traffic; tempo only changes while idle so a gap never overshoots.
        for (int c = 0; c < 600; c++) begin
            host_strobe  = ($urandom_range(0, 3) == 0);
            host_address = 3'($urandom);
            host_data    = 5'($urandom);
            pat_we       = ($urandom_range(0, 3) == 0);
            pat_addr     = 3'($urandom);
            pat_data     = 12'($urandom);
            if ($urandom_range(0, 15) == 0) run = ~run;
            if ($urandom_range(0, 7) == 0) last_step = 3'($urandom);
            if (m_mode == 0 && !run) tempo = 16'($urandom_range(0, 3));
            cyc(1);
        end
        stop_run();

        // Reset asserted while the enables write is pending.
        tempo = 16'd3; last_step = 3'd7; run = 1'b1;
        cyc(3);
        #2 rst = 1'b1;
        #1;
        chk("t6_ws_async", 32'(write_strobe), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_step", 32'(step_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(2);
        chk("t6_zero_per", 32'({write_strobe, address, data}), 32'({1'b1, 3'd0, 5'd0}));
        cyc(1);
        chk("t6_zero_vol", 32'({write_strobe, address, data}), 32'({1'b1, 3'd2, 5'd0}));
        tempo = 16'd1;
        cyc(40);
        stop_run();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
